// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch path: FSM encoding,
// redirect source codes and small address helpers.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StHold = 2'b11
    } fetch_state_e;

    localparam logic [1:0] RedirBranch = 2'b00;
    localparam logic [1:0] RedirJump   = 2'b01;
    localparam logic [1:0] RedirTrap   = 2'b10;
    localparam logic [1:0] RedirReset  = 2'b11;

    localparam logic [31:0] InstrBytes = 32'd4;

    // Instruction fetches are word aligned; low address bits are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential next address; wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + InstrBytes;
    endfunction

endpackage

// File: rtl/Mux4.sv
// Generic 4:1 multiplexer shared across the core datapath.
module Mux4 #(
    parameter int unsigned Width = 32
) (
    input  logic [1:0]       sel,
    input  logic [Width-1:0] in0,
    input  logic [Width-1:0] in1,
    input  logic [Width-1:0] in2,
    input  logic [Width-1:0] in3,
    output logic [Width-1:0] out
);

    always_comb begin
        out = in0;
        unique case (sel)
            2'b00: out = in0;
            2'b01: out = in1;
            2'b10: out = in2;
            2'b11: out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with PC redirect and a
// one-entry holding register toward the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        RedirValid,
    input  logic [1:0]  RedirSel,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] TrapVector,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPc,
    output logic [31:0] PcPlus4
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         drop_q;
    logic         req_q;
    logic         valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;

    logic [31:0]  redir_raw;
    logic [31:0]  redir_target;

    Mux4 #(
        .Width(32)
    ) u_redir_mux (
        .sel(RedirSel),
        .in0(BranchTarget),
        .in1(JumpTarget),
        .in2(TrapVector),
        .in3(RESET_VECTOR),
        .out(redir_raw)
    );

    assign redir_target = word_align(redir_raw);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_VECTOR;
            drop_q     <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            // A redirect always wins the PC; the sequential increment below
            // is only taken when no redirect is present.
            if (RedirValid) begin
                pc_q <= redir_target;
            end

            unique case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                end

                StReq: begin
                    if (ImemGnt) begin
                        // The granted request still targets the old PC, so a
                        // redirect in this cycle marks its response stale.
                        state_q <= StWait;
                        req_q   <= 1'b0;
                        drop_q  <= RedirValid;
                    end else begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                    end
                end

                StWait: begin
                    if (ImemRvalid) begin
                        if (RedirValid || drop_q) begin
                            drop_q  <= 1'b0;
                            state_q <= StReq;
                            req_q   <= 1'b1;
                        end else begin
                            instr_q    <= ImemRdata;
                            instr_pc_q <= pc_q;
                            valid_q    <= 1'b1;
                            pc_q       <= next_pc(pc_q);
                            state_q    <= StHold;
                            req_q      <= 1'b0;
                        end
                    end else begin
                        if (RedirValid) begin
                            drop_q <= 1'b1;
                        end
                        state_q <= StWait;
                        req_q   <= 1'b0;
                    end
                end

                StHold: begin
                    if (RedirValid || !Stall) begin
                        valid_q <= 1'b0;
                        state_q <= StReq;
                        req_q   <= 1'b1;
                    end else begin
                        state_q <= StHold;
                        req_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    drop_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ImemReq    = req_q;
    assign ImemAddr   = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign InstrPc    = instr_pc_q;
    assign PcPlus4    = next_pc(instr_pc_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: straight-line fetch, stall,
// redirects in each state, address wrap and reset mid-request.
module tb_fetch_unit;

    logic        Clk;
    logic        Rst_n;
    logic        Stall;
    logic        RedirValid;
    logic [1:0]  RedirSel;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;
    logic [31:0] TrapVector;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPc;
    logic [31:0] PcPlus4;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_VECTOR(32'h0000_0100)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Stall(Stall),
        .RedirValid(RedirValid),
        .RedirSel(RedirSel),
        .BranchTarget(BranchTarget),
        .JumpTarget(JumpTarget),
        .TrapVector(TrapVector),
        .ImemReq(ImemReq),
        .ImemAddr(ImemAddr),
        .ImemGnt(ImemGnt),
        .ImemRvalid(ImemRvalid),
        .ImemRdata(ImemRdata),
        .InstrValid(InstrValid),
        .Instr(Instr),
        .InstrPc(InstrPc),
        .PcPlus4(PcPlus4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst_n        = 1'b0;
        Stall        = 1'b0;
        RedirValid   = 1'b0;
        RedirSel     = 2'b00;
        BranchTarget = '0;
        JumpTarget   = '0;
        TrapVector   = '0;
        ImemGnt      = 1'b0;
        ImemRvalid   = 1'b0;
        ImemRdata    = '0;

        // Reset state
        step();
        step();
        chk("rst_req", 32'(ImemReq), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_instrpc", InstrPc, 32'h0);
        chk("rst_addr", ImemAddr, 32'h100);

        // Straight-line fetch
        Rst_n = 1'b1;
        step();
        chk("idle_to_req", 32'(ImemReq), 32'd1);
        chk("req_addr", ImemAddr, 32'h100);
        ImemGnt = 1'b1;
        step();
        chk("wait_req_low", 32'(ImemReq), 32'd0);
        ImemGnt    = 1'b0;
        ImemRvalid = 1'b1;
        ImemRdata  = 32'h0050_0093;
        step();
        ImemRvalid = 1'b0;
        chk("sl_valid", 32'(InstrValid), 32'd1);
        chk("sl_instr", Instr, 32'h0050_0093);
        chk("sl_instrpc", InstrPc, 32'h100);
        chk("sl_pcplus4", PcPlus4, 32'h104);
        chk("sl_hold_req", 32'(ImemReq), 32'd0);

        // Stall in HOLD for four cycles
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", 32'(InstrValid), 32'd1);
            chk("stall_instr", Instr, 32'h0050_0093);
            chk("stall_instrpc", InstrPc, 32'h100);
            chk("stall_req", 32'(ImemReq), 32'd0);
        end
        Stall = 1'b0;
        step();
        chk("consume_valid", 32'(InstrValid), 32'd0);
        chk("consume_req", 32'(ImemReq), 32'd1);
        chk("consume_addr", ImemAddr, 32'h104);

        // Redirect during WAIT, response arrives later and is dropped
        ImemGnt = 1'b1;
        step();
        ImemGnt      = 1'b0;
        RedirValid   = 1'b1;
        RedirSel     = 2'b00;
        BranchTarget = 32'h200;
        step();
        RedirValid = 1'b0;
        chk("wredir_addr", ImemAddr, 32'h200);
        chk("wredir_req", 32'(ImemReq), 32'd0);
        step();
        ImemRvalid = 1'b1;
        ImemRdata  = 32'hDEAD_BEEF;
        step();
        ImemRvalid = 1'b0;
        chk("drop_valid", 32'(InstrValid), 32'd0);
        chk("drop_req", 32'(ImemReq), 32'd1);
        chk("drop_addr", ImemAddr, 32'h200);

        // Stray response while in REQ is ignored
        ImemRvalid = 1'b1;
        step();
        ImemRvalid = 1'b0;
        chk("stray_valid", 32'(InstrValid), 32'd0);
        chk("stray_req", 32'(ImemReq), 32'd1);

        // Drop flag cleared: next fetch at 0x200 is delivered
        ImemGnt = 1'b1;
        step();
        ImemGnt    = 1'b0;
        ImemRvalid = 1'b1;
        ImemRdata  = 32'h1111_1111;
        step();
        ImemRvalid = 1'b0;
        chk("post_drop_valid", 32'(InstrValid), 32'd1);
        chk("post_drop_instr", Instr, 32'h1111_1111);
        chk("post_drop_pc", InstrPc, 32'h200);
        step();
        chk("post_drop_addr", ImemAddr, 32'h204);

        // Redirect together with Rvalid in WAIT
        ImemGnt = 1'b1;
        step();
        ImemGnt    = 1'b0;
        ImemRvalid = 1'b1;
        ImemRdata  = 32'hBAD0_BAD0;
        RedirValid = 1'b1;
        RedirSel   = 2'b01;
        JumpTarget = 32'h302;
        step();
        ImemRvalid = 1'b0;
        RedirValid = 1'b0;
        chk("sim_valid", 32'(InstrValid), 32'd0);
        chk("sim_addr", ImemAddr, 32'h300);
        chk("sim_req", 32'(ImemReq), 32'd1);
        ImemGnt = 1'b1;
        step();
        ImemGnt    = 1'b0;
        ImemRvalid = 1'b1;
        ImemRdata  = 32'h2222_2222;
        step();
        ImemRvalid = 1'b0;
        chk("sim_next_valid", 32'(InstrValid), 32'd1);
        chk("sim_next_pc", InstrPc, 32'h300);

        // Redirect in HOLD overrides Stall; trap vector is word aligned
        Stall      = 1'b1;
        RedirValid = 1'b1;
        RedirSel   = 2'b10;
        TrapVector = 32'hFFFF_FFFE;
        step();
        RedirValid = 1'b0;
        Stall      = 1'b0;
        chk("hredir_valid", 32'(InstrValid), 32'd0);
        chk("hredir_req", 32'(ImemReq), 32'd1);
        chk("hredir_addr", ImemAddr, 32'hFFFF_FFFC);

        // Wrap at top of address space
        ImemGnt = 1'b1;
        step();
        ImemGnt    = 1'b0;
        ImemRvalid = 1'b1;
        ImemRdata  = 32'h3333_3333;
        step();
        ImemRvalid = 1'b0;
        chk("wrap_instrpc", InstrPc, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", PcPlus4, 32'h0);
        step();
        chk("wrap_addr", ImemAddr, 32'h0);

        // Redirect to RESET_VECTOR in REQ with Gnt: response is stale
        RedirValid = 1'b1;
        RedirSel   = 2'b11;
        ImemGnt    = 1'b1;
        step();
        RedirValid = 1'b0;
        ImemGnt    = 1'b0;
        chk("rgnt_req", 32'(ImemReq), 32'd0);
        chk("rgnt_addr", ImemAddr, 32'h100);
        ImemRvalid = 1'b1;
        ImemRdata  = 32'h4444_4444;
        step();
        ImemRvalid = 1'b0;
        chk("rgnt_drop_valid", 32'(InstrValid), 32'd0);
        chk("rgnt_drop_req", 32'(ImemReq), 32'd1);

        // Redirect in REQ without Gnt
        RedirValid   = 1'b1;
        RedirSel     = 2'b00;
        BranchTarget = 32'h403;
        step();
        RedirValid = 1'b0;
        chk("rnogt_req", 32'(ImemReq), 32'd1);
        chk("rnogt_addr", ImemAddr, 32'h400);

        // Reset mid-WAIT then a stray response
        ImemGnt = 1'b1;
        step();
        ImemGnt = 1'b0;
        Rst_n   = 1'b0;
        step();
        chk("midrst_req", 32'(ImemReq), 32'd0);
        chk("midrst_valid", 32'(InstrValid), 32'd0);
        chk("midrst_addr", ImemAddr, 32'h100);
        Rst_n      = 1'b1;
        ImemRvalid = 1'b1;
        ImemRdata  = 32'h5555_5555;
        step();
        chk("midrst_req2", 32'(ImemReq), 32'd1);
        chk("midrst_valid2", 32'(InstrValid), 32'd0);
        chk("midrst_addr2", ImemAddr, 32'h100);
        step();
        ImemRvalid = 1'b0;
        chk("midrst_valid3", 32'(InstrValid), 32'd0);
        chk("midrst_req3", 32'(ImemReq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
